// File: rtl/load_store_queue.sv
// In-order circular load/store queue between issue/ROB and the memory controller.
// Tracks occupancy, gates IO loads on ROB head, extends load data and squashes in-flight loads on flush.
module load_store_queue #(
  parameter int          LSB_WIDTH = 4,
  parameter int          ROB_WIDTH = 4,
  parameter logic [31:0] IO_BASE   = 32'h0003_0000
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear_signal,
  input  logic                 issue_signal,
  input  logic                 issue_wr,
  input  logic [1:0]           issue_len,
  input  logic                 issue_signed,
  input  logic [31:0]          issue_addr,
  input  logic                 issue_valid_addr,
  input  logic [ROB_WIDTH-1:0] issue_tag_addr,
  input  logic [ROB_WIDTH-1:0] issue_tag_rd,
  input  logic                 cdb_signal,
  input  logic [31:0]          cdb_value,
  input  logic [ROB_WIDTH-1:0] cdb_tag,
  input  logic                 commit_signal,
  input  logic [31:0]          commit_value,
  input  logic [ROB_WIDTH-1:0] commit_tag,
  input  logic [ROB_WIDTH-1:0] rob_head_tag,
  output logic                 mem_signal,
  output logic                 mem_wr,
  output logic [1:0]           mem_len,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_dout,
  input  logic [31:0]          mem_din,
  input  logic                 mem_done,
  output logic                 done_signal,
  output logic [31:0]          done_value,
  output logic [ROB_WIDTH-1:0] done_tag,
  output logic                 full,
  output logic                 empty,
  output logic [LSB_WIDTH:0]   count
);
  localparam int LSB_SIZE = 2 ** LSB_WIDTH;

  typedef enum logic [1:0] {IDLE, MEM, DRAIN} state_t;

  state_t                r_state;
  logic [LSB_SIZE-1:0]   r_busy, r_addrOk, r_committed, r_wr, r_signed;
  logic [1:0]            r_len     [LSB_SIZE];
  logic [31:0]           r_addr    [LSB_SIZE];
  logic [31:0]           r_value   [LSB_SIZE];
  logic [ROB_WIDTH-1:0]  r_tagAddr [LSB_SIZE];
  logic [ROB_WIDTH-1:0]  r_tagRd   [LSB_SIZE];
  logic [LSB_WIDTH-1:0]  r_head, r_tail;
  logic [LSB_WIDTH:0]    r_count;

  logic                  w_full, w_push, w_bypass, w_headIsIo, w_headEligible;
  logic                  w_complete, w_squash, w_run;
  logic [LSB_SIZE-1:0]   w_effComm, w_keep;
  logic [LSB_WIDTH:0]    w_nComm;
  logic [LSB_WIDTH-1:0]  w_idx;

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] len,
                                         input logic sgn);
    case (len)
      2'd0:    extend = {{24{sgn & d[7]}}, d[7:0]};
      2'd1:    extend = {{16{sgn & d[15]}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  assign w_full         = (r_count == (LSB_WIDTH+1)'(LSB_SIZE));
  assign full           = w_full;
  assign empty          = (r_count == '0);
  assign count          = r_count;
  assign w_push         = issue_signal && !w_full && !clear_signal;
  assign w_bypass       = !issue_valid_addr && cdb_signal && (cdb_tag == issue_tag_addr);
  assign w_headIsIo     = (r_addr[r_head] >= IO_BASE);
  assign w_headEligible = r_busy[r_head] && r_addrOk[r_head] &&
                          (r_wr[r_head] ? r_committed[r_head]
                                        : (!w_headIsIo || rob_head_tag == r_tagRd[r_head]));
  assign w_complete     = (r_state == MEM) && mem_done;
  assign w_squash       = (r_state == MEM) && clear_signal && !r_wr[r_head];

  // Committed stores (including one committing this edge) form a run from head; a flush keeps only that run.
  always_comb begin
    w_nComm = '0;
    w_run   = 1'b1;
    w_idx   = r_head;
    w_keep  = '0;
    for (int i = 0; i < LSB_SIZE; i++) begin
      w_effComm[i] = r_busy[i] && r_wr[i] &&
                     (r_committed[i] || (commit_signal && r_tagRd[i] == commit_tag));
    end
    for (int i = 0; i < LSB_SIZE; i++) begin
      w_idx = r_head + LSB_WIDTH'(i);
      if (w_run && w_effComm[w_idx]) w_nComm = w_nComm + (LSB_WIDTH+1)'(1);
      else                           w_run   = 1'b0;
    end
    for (int i = 0; i < LSB_SIZE; i++) begin
      w_keep[i] = ({1'b0, LSB_WIDTH'(i) - r_head} < w_nComm);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= IDLE;
      r_busy <= '0; r_addrOk <= '0; r_committed <= '0; r_wr <= '0; r_signed <= '0;
      for (int i = 0; i < LSB_SIZE; i++) begin
        r_len[i] <= '0; r_addr[i] <= '0; r_value[i] <= '0;
        r_tagAddr[i] <= '0; r_tagRd[i] <= '0;
      end
      r_head <= '0; r_tail <= '0; r_count <= '0;
      mem_signal <= 1'b0; mem_wr <= 1'b0; mem_len <= '0; mem_addr <= '0; mem_dout <= '0;
      done_signal <= 1'b0; done_value <= '0; done_tag <= '0;
    end else if (rdy_in) begin
      done_signal <= 1'b0;
      for (int i = 0; i < LSB_SIZE; i++) begin
        if (cdb_signal && r_busy[i] && !r_addrOk[i] && r_tagAddr[i] == cdb_tag) begin
          r_addr[i]   <= cdb_value;
          r_addrOk[i] <= 1'b1;
        end
        if (commit_signal && r_busy[i] && r_wr[i] && r_tagRd[i] == commit_tag) begin
          r_value[i]     <= commit_value;
          r_committed[i] <= 1'b1;
        end
      end

      case (r_state)
        IDLE: if (w_headEligible && !clear_signal) begin
          mem_signal <= 1'b1;
          mem_wr     <= r_wr[r_head];
          mem_len    <= r_len[r_head];
          mem_addr   <= r_addr[r_head];
          mem_dout   <= r_value[r_head];
          r_state    <= MEM;
        end
        MEM: if (mem_done) begin
          mem_signal <= 1'b0;
          r_state    <= IDLE;
          if (!r_wr[r_head] && !clear_signal) begin
            done_signal <= 1'b1;
            done_value  <= extend(mem_din, r_len[r_head], r_signed[r_head]);
            done_tag    <= r_tagRd[r_head];
          end
        end else if (w_squash) begin
          r_state <= DRAIN;
        end
        DRAIN: if (mem_done) begin
          mem_signal <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // A squashed in-flight load still occupies the head slot, so both pointers step past it.
      if (clear_signal) begin
        for (int i = 0; i < LSB_SIZE; i++) begin
          if (!w_keep[i]) begin
            r_busy[i] <= 1'b0; r_addrOk[i] <= 1'b0; r_committed[i] <= 1'b0;
          end
        end
        if (w_squash) begin
          r_head  <= r_head + LSB_WIDTH'(1);
          r_tail  <= r_head + LSB_WIDTH'(1);
          r_count <= '0;
        end else begin
          r_head  <= r_head + LSB_WIDTH'(w_complete);
          r_tail  <= r_head + w_nComm[LSB_WIDTH-1:0];
          r_count <= w_nComm - {{LSB_WIDTH{1'b0}}, w_complete};
          if (w_complete) begin
            r_busy[r_head] <= 1'b0; r_addrOk[r_head] <= 1'b0; r_committed[r_head] <= 1'b0;
          end
        end
      end else begin
        if (w_complete) begin
          r_busy[r_head] <= 1'b0; r_addrOk[r_head] <= 1'b0; r_committed[r_head] <= 1'b0;
        end
        if (w_push) begin
          r_busy[r_tail]      <= 1'b1;
          r_addrOk[r_tail]    <= issue_valid_addr || w_bypass;
          r_committed[r_tail] <= 1'b0;
          r_wr[r_tail]        <= issue_wr;
          r_len[r_tail]       <= issue_len;
          r_signed[r_tail]    <= issue_signed;
          r_addr[r_tail]      <= issue_valid_addr ? issue_addr : cdb_value;
          r_value[r_tail]     <= '0;
          r_tagAddr[r_tail]   <= issue_tag_addr;
          r_tagRd[r_tail]     <= issue_tag_rd;
          r_tail              <= r_tail + LSB_WIDTH'(1);
        end
        r_head  <= r_head + LSB_WIDTH'(w_complete);
        r_count <= r_count + {{LSB_WIDTH{1'b0}}, w_push} - {{LSB_WIDTH{1'b0}}, w_complete};
      end
    end
  end
endmodule

// File: tb/tb_load_store_queue.sv
// Self-checking bench for load_store_queue: scenario tasks plus a randomized queue model
// that predicts memory request order, store data and extended load results.
module tb_load_store_queue;
  logic        clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1, clear_signal = 1'b0;
  logic        issue_signal = 1'b0, issue_wr = 1'b0, issue_signed = 1'b0, issue_valid_addr = 1'b0;
  logic [1:0]  issue_len = '0;
  logic [31:0] issue_addr = '0;
  logic [3:0]  issue_tag_addr = '0, issue_tag_rd = '0;
  logic        cdb_signal = 1'b0, commit_signal = 1'b0, mem_done = 1'b0;
  logic [31:0] cdb_value = '0, commit_value = '0, mem_din = '0;
  logic [3:0]  cdb_tag = '0, commit_tag = '0, rob_head_tag = '0;
  logic        mem_signal, mem_wr, done_signal, full, empty;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr, mem_dout, done_value;
  logic [3:0]  done_tag;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  len;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  tag;
  } op_t;
  op_t model[$];

  load_store_queue #(.LSB_WIDTH(4), .ROB_WIDTH(4), .IO_BASE(32'h0003_0000)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_signal(clear_signal),
    .issue_signal(issue_signal), .issue_wr(issue_wr), .issue_len(issue_len),
    .issue_signed(issue_signed), .issue_addr(issue_addr), .issue_valid_addr(issue_valid_addr),
    .issue_tag_addr(issue_tag_addr), .issue_tag_rd(issue_tag_rd),
    .cdb_signal(cdb_signal), .cdb_value(cdb_value), .cdb_tag(cdb_tag),
    .commit_signal(commit_signal), .commit_value(commit_value), .commit_tag(commit_tag),
    .rob_head_tag(rob_head_tag),
    .mem_signal(mem_signal), .mem_wr(mem_wr), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .mem_din(mem_din), .mem_done(mem_done),
    .done_signal(done_signal), .done_value(done_value), .done_tag(done_tag),
    .full(full), .empty(empty), .count(count)
  );

  always #5 clk_in = ~clk_in;

  // Reference extension: keep the low width bits, then reinterpret as signed if requested.
  function automatic logic [31:0] extRef(input logic [31:0] d, input logic [1:0] len, input logic sgn);
    longint width, v;
    width = (len == 2'd0) ? 8 : (len == 2'd1) ? 16 : 32;
    if (width == 32) return d;
    v = longint'(d) % (longint'(1) << width);
    if (sgn && v >= (longint'(1) << (width - 1))) v = v - (longint'(1) << width);
    return v[31:0];
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic doIssue(input logic wr, input logic [1:0] len, input logic sgn,
                         input logic [31:0] addr, input logic [3:0] tag);
    issue_signal = 1'b1; issue_wr = wr; issue_len = len; issue_signed = sgn;
    issue_addr = addr; issue_valid_addr = 1'b1; issue_tag_rd = tag; issue_tag_addr = 4'd0;
    tick();
    issue_signal = 1'b0; issue_valid_addr = 1'b0;
  endtask

  task automatic waitMem(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (mem_signal) begin ok = 1'b1; return; end
      tick();
    end
    ok = mem_signal;
  endtask

  task automatic serve(input logic [31:0] data);
    mem_din = data; mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (mem_signal !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_signal got %0b want 0", mem_signal); end
    checks++; if (done_signal !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0b want 0", done_signal); end
    checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got %0b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %0b want 0", full); end
    checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", count); end
    rst_in = 1'b1;
    tick();
  endtask

  task automatic test_load_sext();
    doIssue(1'b0, 2'd0, 1'b1, 32'h1000, 4'd7);
    checks++; if (mem_signal !== 1'b0) begin errors++; $display("[TB] FAIL ld_early_req got %0b want 0", mem_signal); end
    checks++; if (count !== 5'd1) begin errors++; $display("[TB] FAIL ld_count got %0d want 1", count); end
    tick();
    checks++; if (mem_signal !== 1'b1) begin errors++; $display("[TB] FAIL ld_req got %0b want 1", mem_signal); end
    checks++; if (mem_addr !== 32'h1000 || mem_wr !== 1'b0 || mem_len !== 2'd0) begin
      errors++; $display("[TB] FAIL ld_fields got addr %h wr %0b len %0d want 1000 0 0", mem_addr, mem_wr, mem_len); end
    tick();
    serve(32'h0000_0080);
    checks++; if (done_signal !== 1'b1 || done_value !== 32'hFFFF_FF80 || done_tag !== 4'd7) begin
      errors++; $display("[TB] FAIL ld_done got %0b %h %0d want 1 ffffff80 7", done_signal, done_value, done_tag); end
    checks++; if (mem_signal !== 1'b0) begin errors++; $display("[TB] FAIL ld_drop got %0b want 0", mem_signal); end
    tick();
    checks++; if (done_signal !== 1'b0) begin errors++; $display("[TB] FAIL ld_pulse_len got %0b want 0", done_signal); end
    checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL ld_count_end got %0d want 0", count); end
  endtask

  task automatic test_store();
    bit ok;
    doIssue(1'b1, 2'd2, 1'b0, 32'h2000, 4'd3);
    repeat (3) tick();
    checks++; if (mem_signal !== 1'b0) begin errors++; $display("[TB] FAIL st_uncommitted_req got %0b want 0", mem_signal); end
    checks++; if (count !== 5'd1) begin errors++; $display("[TB] FAIL st_count got %0d want 1", count); end
    commit_signal = 1'b1; commit_tag = 4'd3; commit_value = 32'hDEAD_BEEF;
    tick();
    commit_signal = 1'b0;
    waitMem(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL st_timeout got 0 want 1"); end
    checks++; if (mem_wr !== 1'b1 || mem_dout !== 32'hDEAD_BEEF || mem_addr !== 32'h2000) begin
      errors++; $display("[TB] FAIL st_fields got wr %0b dout %h addr %h want 1 deadbeef 2000", mem_wr, mem_dout, mem_addr); end
    serve(32'h1234_5678);
    checks++; if (done_signal !== 1'b0) begin errors++; $display("[TB] FAIL st_done got %0b want 0", done_signal); end
    checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL st_count_end got %0d want 0", count); end
  endtask

  task automatic test_fill_wrap();
    bit ok;
    op_t o, e;
    int n;
    logic [31:0] rd;
    for (int r = 0; r < 3; r++) begin
      n = (r == 0) ? 16 : int'($urandom_range(12, 3));
      model.delete();
      for (int i = 0; i < n; i++) begin
        o.wr = 1'($urandom_range(1, 0)); o.len = 2'($urandom_range(2, 0)); o.sgn = 1'($urandom_range(1, 0));
        o.addr = $urandom_range(32'h0002_FFFF, 32'h0000_0100); o.data = $urandom; o.tag = 4'(i);
        model.push_back(o);
        doIssue(o.wr, o.len, o.sgn, o.addr, o.tag);
      end
      checks++; if (count !== 5'(n) || full !== (n == 16)) begin
        errors++; $display("[TB] FAIL fill_count got %0d full %0b want %0d", count, full, n); end
      foreach (model[i]) if (model[i].wr) begin
        commit_signal = 1'b1; commit_tag = model[i].tag; commit_value = model[i].data;
        tick();
      end
      commit_signal = 1'b0;
      for (int k = 0; k < n; k++) begin
        waitMem(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL fill_timeout op %0d", k); end
        e = model.pop_front();
        checks++; if (mem_wr !== e.wr || mem_addr !== e.addr || mem_len !== e.len || (e.wr && mem_dout !== e.data)) begin
          errors++; $display("[TB] FAIL fill_req op %0d got wr %0b addr %h len %0d dout %h want %0b %h %0d %h",
                             k, mem_wr, mem_addr, mem_len, mem_dout, e.wr, e.addr, e.len, e.data); end
        repeat ($urandom_range(2, 0)) tick();
        rd = $urandom;
        serve(rd);
        if (e.wr) begin
          checks++; if (done_signal !== 1'b0) begin errors++; $display("[TB] FAIL fill_st_done op %0d got 1 want 0", k); end
        end else begin
          checks++; if (done_signal !== 1'b1 || done_value !== extRef(rd, e.len, e.sgn) || done_tag !== e.tag) begin
            errors++; $display("[TB] FAIL fill_ld_done op %0d got %0b %h %0d want 1 %h %0d",
                               k, done_signal, done_value, done_tag, extRef(rd, e.len, e.sgn), e.tag); end
        end
        checks++; if (mem_signal !== 1'b0 || count !== 5'(n - 1 - k)) begin
          errors++; $display("[TB] FAIL fill_after op %0d got mem %0b count %0d want 0 %0d", k, mem_signal, count, n - 1 - k); end
      end
    end
  endtask

  task automatic test_io();
    bit ok;
    logic [31:0] rd;
    rob_head_tag = 4'd0;
    doIssue(1'b0, 2'd2, 1'b0, 32'h0003_0000, 4'd5);
    repeat (4) tick();
    checks++; if (mem_signal !== 1'b0) begin errors++; $display("[TB] FAIL io_blocked got %0b want 0", mem_signal); end
    rob_head_tag = 4'd5;
    tick();
    checks++; if (mem_signal !== 1'b1 || mem_addr !== 32'h0003_0000) begin
      errors++; $display("[TB] FAIL io_req got %0b %h want 1 30000", mem_signal, mem_addr); end
    rd = $urandom;
    serve(rd);
    checks++; if (done_signal !== 1'b1 || done_value !== rd || done_tag !== 4'd5) begin
      errors++; $display("[TB] FAIL io_done got %0b %h %0d want 1 %h 5", done_signal, done_value, done_tag, rd); end
    rob_head_tag = 4'd0;
    waitMem(ok);
  endtask

  task automatic test_clear_inflight();
    bit ok, sawDone, sawReq, dropped;
    doIssue(1'b0, 2'd2, 1'b0, 32'h0000_4000, 4'd1);
    doIssue(1'b0, 2'd1, 1'b1, 32'h0000_4004, 4'd2);
    doIssue(1'b0, 2'd0, 1'b0, 32'h0000_4008, 4'd3);
    checks++; if (mem_signal !== 1'b1 || count !== 5'd3) begin
      errors++; $display("[TB] FAIL clr_ld_setup got mem %0b count %0d want 1 3", mem_signal, count); end
    clear_signal = 1'b1;
    tick();
    clear_signal = 1'b0;
    checks++; if (count !== 5'd0 || empty !== 1'b1 || done_signal !== 1'b0) begin
      errors++; $display("[TB] FAIL clr_ld_count got %0d done %0b want 0 0", count, done_signal); end
    dropped = 1'b0;
    repeat (3) begin tick(); if (!mem_signal) dropped = 1'b1; end
    checks++; if (dropped) begin errors++; $display("[TB] FAIL clr_ld_hold got 0 want 1"); end
    serve(32'hFFFF_FFFF);
    sawDone = done_signal; sawReq = mem_signal;
    repeat (5) begin tick(); sawDone |= done_signal; sawReq |= mem_signal; end
    checks++; if (sawDone) begin errors++; $display("[TB] FAIL clr_ld_done got 1 want 0"); end
    checks++; if (sawReq) begin errors++; $display("[TB] FAIL clr_ld_req got 1 want 0"); end
  endtask

  task automatic test_clear_store();
    bit ok, sawReq;
    doIssue(1'b1, 2'd2, 1'b0, 32'h0000_5000, 4'd1);
    doIssue(1'b0, 2'd2, 1'b0, 32'h0000_5004, 4'd2);
    doIssue(1'b0, 2'd2, 1'b0, 32'h0000_5008, 4'd3);
    commit_signal = 1'b1; commit_tag = 4'd1; commit_value = 32'hCAFE_0001; clear_signal = 1'b1;
    tick();
    commit_signal = 1'b0; clear_signal = 1'b0;
    checks++; if (count !== 5'd1) begin errors++; $display("[TB] FAIL clr_st_count got %0d want 1", count); end
    waitMem(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL clr_st_timeout got 0 want 1"); end
    checks++; if (mem_wr !== 1'b1 || mem_dout !== 32'hCAFE_0001 || mem_addr !== 32'h0000_5000) begin
      errors++; $display("[TB] FAIL clr_st_fields got %0b %h %h want 1 cafe0001 5000", mem_wr, mem_dout, mem_addr); end
    serve(32'h0);
    checks++; if (done_signal !== 1'b0 || count !== 5'd0) begin
      errors++; $display("[TB] FAIL clr_st_end got done %0b count %0d want 0 0", done_signal, count); end
    sawReq = 1'b0;
    repeat (4) begin tick(); sawReq |= mem_signal; end
    checks++; if (sawReq) begin errors++; $display("[TB] FAIL clr_st_extra_req got 1 want 0"); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] v1, v2, a3, d;
    v1 = $urandom_range(32'h0002_0000, 32'h100); v2 = $urandom_range(32'h0002_0000, 32'h100);
    a3 = $urandom_range(32'h0002_0000, 32'h100);
    issue_signal = 1'b1; issue_wr = 1'b0; issue_len = 2'd2; issue_signed = 1'b0;
    issue_valid_addr = 1'b0; issue_tag_addr = 4'd9; issue_tag_rd = 4'd1;
    tick();
    issue_tag_addr = 4'd6; issue_tag_rd = 4'd2;
    cdb_signal = 1'b1; cdb_tag = 4'd6; cdb_value = v2;
    tick();
    issue_signal = 1'b0; cdb_signal = 1'b0;
    repeat (2) tick();
    checks++; if (mem_signal !== 1'b0 || count !== 5'd2) begin
      errors++; $display("[TB] FAIL b2b_wait got mem %0b count %0d want 0 2", mem_signal, count); end
    cdb_signal = 1'b1; cdb_tag = 4'd9; cdb_value = v1;
    tick();
    cdb_signal = 1'b0;
    waitMem(ok);
    checks++; if (!ok || mem_addr !== v1) begin errors++; $display("[TB] FAIL b2b_cdb_addr got %h want %h", mem_addr, v1); end
    d = $urandom;
    issue_signal = 1'b1; issue_valid_addr = 1'b1; issue_addr = a3; issue_tag_rd = 4'd3;
    serve(d);
    issue_signal = 1'b0; issue_valid_addr = 1'b0;
    checks++; if (count !== 5'd2) begin errors++; $display("[TB] FAIL b2b_count got %0d want 2", count); end
    checks++; if (done_signal !== 1'b1 || done_value !== d || done_tag !== 4'd1) begin
      errors++; $display("[TB] FAIL b2b_done got %0b %h %0d want 1 %h 1", done_signal, done_value, done_tag, d); end
    waitMem(ok);
    checks++; if (!ok || mem_addr !== v2) begin errors++; $display("[TB] FAIL b2b_bypass_addr got %h want %h", mem_addr, v2); end
    serve(32'h0);
    waitMem(ok);
    checks++; if (!ok || mem_addr !== a3) begin errors++; $display("[TB] FAIL b2b_third_addr got %h want %h", mem_addr, a3); end
    serve(32'h0);
    checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL b2b_count_end got %0d want 0", count); end
  endtask

  task automatic test_rdy();
    bit ok;
    doIssue(1'b0, 2'd1, 1'b1, 32'h0000_6000, 4'd4);
    waitMem(ok);
    rdy_in = 1'b0; mem_din = 32'h0000_8001; mem_done = 1'b1;
    repeat (2) tick();
    mem_done = 1'b0;
    checks++; if (mem_signal !== 1'b1 || count !== 5'd1 || done_signal !== 1'b0) begin
      errors++; $display("[TB] FAIL rdy_freeze got mem %0b count %0d done %0b want 1 1 0", mem_signal, count, done_signal); end
    rdy_in = 1'b1;
    tick();
    serve(32'h0000_8001);
    checks++; if (done_signal !== 1'b1 || done_value !== 32'hFFFF_8001) begin
      errors++; $display("[TB] FAIL rdy_done got %0b %h want 1 ffff8001", done_signal, done_value); end
  endtask

  task automatic test_reset_mid();
    bit ok, sawReq;
    doIssue(1'b0, 2'd2, 1'b0, 32'h0000_7000, 4'd8);
    doIssue(1'b0, 2'd2, 1'b0, 32'h0000_7004, 4'd9);
    waitMem(ok);
    rst_in = 1'b0;
    #1;
    checks++; if (mem_signal !== 1'b0 || count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || done_signal !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_mid got mem %0b count %0d empty %0b want 0 0 1", mem_signal, count, empty); end
    tick();
    rst_in = 1'b1;
    sawReq = 1'b0;
    repeat (4) begin tick(); sawReq |= mem_signal; end
    checks++; if (sawReq) begin errors++; $display("[TB] FAIL rst_mid_req got 1 want 0"); end
  endtask

  initial begin
    tick();
    tick();
    test_reset();
    test_load_sext();
    test_store();
    test_fill_wrap();
    test_io();
    test_clear_inflight();
    test_clear_store();
    test_back_to_back();
    test_rdy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
